param_seq_detector: RTL and testbench
=====================================

# param_seq_detector

Parametrised, runtime-programmable serial bit-pattern detector; successor to the fixed 4-bit Moore sequence detector. Accepts one qualified bit per cycle, compares the last N received bits against a loadable pattern of length 1..MAX_LEN, and raises a Moore-style registered detect output. Supports overlapping and non-overlapping modes and keeps a saturating match count. Sits directly on the serial input path, ahead of any framing/sync logic.

## Interface
Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- CNT_W, 8, width of match counter
- DEFAULT_PATTERN, 'b1011, pattern after reset (right-aligned in MAX_LEN bits)
- DEFAULT_LEN, 4, pattern length after reset
- LEN_W, $clog2(MAX_LEN)+1, derived; width of length fields

Ports (one clock, `clock`; reset `reset` is synchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- sequence_in  in  1  serial data bit
- in_valid  in  1  sequence_in sampled only when high
- cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] = first bit received, bit [0] = last
- cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- detector_out  out  1  high while FSM is in MATCH
- match_count  out  CNT_W  saturating number of detections since reset/load
- cfg_err  out  1  high while loaded cfg_len is illegal

## Operation
- Internal: hist (MAX_LEN-bit shift register), fill (LEN_W-bit count of valid history bits, saturates at len), pat/len/ovl config registers.
- FSM states: FILL (fill < len), ARMED (fill = len, last compare failed), MATCH (last accepted bit completed pattern), ERR (illegal config).
- Accepted bit (in_valid=1, state ≠ ERR): hist_n = {hist[MAX_LEN-2:0], sequence_in}; fill_n = min(fill+1, len); hit = (fill_n = len) and (hist_n[len-1:0] = pat[len-1:0]).
- hit → MATCH, match_count += 1 (saturate at 2^CNT_W-1). Non-overlap mode: fill reset to 0 on hit (next match needs len fresh bits). Overlap mode: fill stays len.
- No hit → ARMED if fill_n = len, else FILL.
- in_valid=0: all state, hist, fill, outputs hold (detector_out stays high in MATCH until next accepted bit).
- cfg_load: latch config; clear hist, fill, match_count; next state FILL, or ERR if cfg_len = 0 or > MAX_LEN. Bit presented same cycle is discarded (load wins).
- ERR: ignores data; detector_out=0; left only by a legal cfg_load or reset.
- Reset: pat=DEFAULT_PATTERN, len=DEFAULT_LEN, ovl=1, state FILL, hist=0, fill=0.

## Timing
- Reset values: detector_out=0, match_count=0, cfg_err=0.
- Latency: detector_out rises on the clock edge that samples the final pattern bit (visible the following cycle); Moore output, no combinational path from sequence_in.
- match_count updates on the same edge as detector_out.
- cfg_err is registered; asserts the cycle after an illegal cfg_load, clears the cycle after a legal one.
- reset has priority over cfg_load; cfg_load over in_valid.
- Back-to-back overlapping matches (e.g. pattern 11, stream 111) keep detector_out high continuously; count increments every matching bit.
- len = 1: every matching accepted bit is a detection in both modes.

## Structure
- Package seq_det_pkg: state enum (FILL, ARMED, MATCH, ERR), LEN_W helper function, default constants.
- Sub-module sat_counter (WIDTH param, inc, clr; saturating) for match_count. FSM, history and compare in the top.

## Test plan
- Default config, reset released, stream 1,0,1,1,0,1,1 → detector_out high after bits 4 and 7, match_count=2.
- cfg_overlap=0, pattern 11 len 2, stream 1,1,1,1 → detects after bits 2 and 4 only, match_count=2; overlap=1 → bits 2,3,4, count=3.
- Same stream with in_valid low for 3 cycles between bits → identical detections, detector_out held through gaps.
- cfg_load pattern 8'b1100_1010 len 8 mid-stream, with in_valid same cycle → count cleared, bit dropped, detect only after 8 further matching bits.
- cfg_len=0 → cfg_err=1, no detection on 1011; then legal load → cfg_err=0, detection resumes.
- CNT_W=2, pattern len 1 = 1, six 1s → count saturates at 3; reset asserted while in MATCH → detector_out=0, count=0 next cycle.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

  // Detector FSM states
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ARMED = 2'd1,
    ST_MATCH = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  // Width of a length field able to hold 0..max_len (and max_len+1 transiently)
  function automatic int len_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  localparam int         DEF_MAX_LEN      = 8;
  localparam int         DEF_CNT_W        = 8;
  localparam int         DEF_LEN          = 4;
  localparam logic [3:0] DEF_PATTERN_BITS = 4'b1011;

endpackage

// File: rtl/param_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count accepted increments, stopping at the maximum value
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial bit-pattern detector with Moore detect output,
// overlap/non-overlap modes and a saturating match counter.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                   MAX_LEN         = DEF_MAX_LEN,
  parameter int                   CNT_W           = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN_BITS),
  parameter int                   DEFAULT_LEN     = DEF_LEN,
  parameter int                   LEN_W           = len_width(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sequence_in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               detector_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  state_e             state_r;
  logic [MAX_LEN-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic               det_r;
  logic               err_r;

  logic [MAX_LEN-1:0] hist_n_s;
  logic [LEN_W-1:0]   fill_n_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               hit_s;
  logic               accept_s;
  logic               cfg_bad_s;

  // Next history/fill values and pattern compare for the bit on the input
  always_comb begin
    hist_n_s = (hist_r << 1) | MAX_LEN'(sequence_in);
    if ((fill_r + LEN_W'(1)) >= len_r) begin
      fill_n_s = len_r;
    end else begin
      fill_n_s = fill_r + LEN_W'(1);
    end
    mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_r);
    end
    hit_s     = (fill_n_s == len_r) && (((hist_n_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
    accept_s  = in_valid && !cfg_load && (state_r != ST_ERR);
    cfg_bad_s = (cfg_len == {LEN_W{1'b0}}) || (cfg_len > LEN_W'(MAX_LEN));
  end

  // Detector FSM: configuration, history shift and registered detect/error flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_FILL;
      hist_r  <= {MAX_LEN{1'b0}};
      fill_r  <= {LEN_W{1'b0}};
      pat_r   <= DEFAULT_PATTERN;
      len_r   <= LEN_W'(DEFAULT_LEN);
      ovl_r   <= 1'b1;
      det_r   <= 1'b0;
      err_r   <= 1'b0;
    end else if (cfg_load) begin
      // Load wins over any data bit presented in the same cycle
      pat_r  <= cfg_pattern;
      len_r  <= cfg_len;
      ovl_r  <= cfg_overlap;
      hist_r <= {MAX_LEN{1'b0}};
      fill_r <= {LEN_W{1'b0}};
      det_r  <= 1'b0;
      if (cfg_bad_s) begin
        state_r <= ST_ERR;
        err_r   <= 1'b1;
      end else begin
        state_r <= ST_FILL;
        err_r   <= 1'b0;
      end
    end else if (accept_s) begin
      hist_r <= hist_n_s;
      if (hit_s) begin
        state_r <= ST_MATCH;
        det_r   <= 1'b1;
        // Non-overlap mode needs a full pattern of fresh bits for the next hit
        fill_r  <= ovl_r ? len_r : {LEN_W{1'b0}};
      end else begin
        state_r <= (fill_n_s == len_r) ? ST_ARMED : ST_FILL;
        det_r   <= 1'b0;
        fill_r  <= fill_n_s;
      end
    end else begin
      state_r <= state_r;
      hist_r  <= hist_r;
      fill_r  <= fill_r;
      det_r   <= det_r;
      err_r   <= err_r;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cfg_load),
    .inc   (accept_s && hit_s),
    .count (match_count)
  );

  assign detector_out = det_r;
  assign cfg_err      = err_r;

endmodule

// File: tb/tb_param_seq_detector.sv
// Self-checking bench for param_seq_detector: queue-based reference model
// compared every cycle, plus hand-computed pins at key points.
module tb_param_seq_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               sequence_in = 1'b0;
  logic               in_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = 8'h00;
  logic [LEN_W-1:0]   cfg_len = 4'd0;
  logic               cfg_overlap = 1'b0;
  logic               detector_out;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  param_seq_detector #(
    .MAX_LEN         (MAX_LEN),
    .CNT_W           (CNT_W),
    .DEFAULT_PATTERN (8'b0000_1011),
    .DEFAULT_LEN     (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .in_valid     (in_valid),
    .cfg_load     (cfg_load),
    .cfg_pattern  (cfg_pattern),
    .cfg_len      (cfg_len),
    .cfg_overlap  (cfg_overlap),
    .detector_out (detector_out),
    .match_count  (match_count),
    .cfg_err      (cfg_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: bits since last clear kept in a queue, last len compared to pattern
  logic         q[$];
  logic [7:0]   m_pat = 8'b0000_1011;
  int           m_len = 4;
  logic         m_ovl = 1'b1;
  logic         m_err = 1'b0;
  logic         m_det = 1'b0;
  int           m_cnt = 0;
  bit           m_hit;
  int           m_max = (1 << CNT_W) - 1;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        q.delete();
        m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
        m_err = 1'b0; m_det = 1'b0; m_cnt = 0;
      end else if (cfg_load) begin
        q.delete();
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
        m_err = (m_len == 0) || (m_len > MAX_LEN);
        m_det = 1'b0; m_cnt = 0;
      end else if (in_valid && !m_err) begin
        q.push_back(sequence_in);
        while (q.size() > m_len) void'(q.pop_front());
        m_hit = (q.size() == m_len);
        for (int i = 0; i < q.size(); i++) begin
          if (q[i] !== m_pat[m_len-1-i]) m_hit = 1'b0;
        end
        m_det = m_hit;
        if (m_hit) begin
          if (m_cnt < m_max) m_cnt++;
          if (!m_ovl) q.delete();
        end
      end
      #1;
      check("model_det", 32'(detector_out), 32'(m_det));
      check("model_cnt", 32'(match_count), 32'(m_cnt));
      check("model_err", 32'(cfg_err), 32'(m_err));
    end
  end

  task automatic step(input logic v, input logic b);
    @(negedge clock);
    reset = 1'b0; cfg_load = 1'b0; in_valid = v; sequence_in = b;
    @(posedge clock);
    #2;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic v, input logic b);
    @(negedge clock);
    reset = 1'b0; cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    in_valid = v; sequence_in = b;
    @(posedge clock);
    #2;
  endtask

  // Send n bits MSB first and pin detector_out after each against exp (MSB first)
  task automatic send_pin(input string name, input logic [7:0] bits,
                          input logic [7:0] exp, input int n);
    logic [7:0] b;
    logic [7:0] e;
    b = bits;
    e = exp;
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, b[i]);
      check(name, 32'(detector_out), 32'(e[i]));
    end
  endtask

  initial begin
    // Reset state
    @(posedge clock); @(posedge clock); #2;
    check("reset_det", 32'(detector_out), 32'd0);
    check("reset_cnt", 32'(match_count), 32'd0);
    check("reset_err", 32'(cfg_err), 32'd0);

    // Default 1011 overlap: stream 1011011 hits after bits 4 and 7
    send_pin("default_det", 8'b0101_1011, 8'b0000_1001, 7);
    check("default_cnt", 32'(match_count), 32'd2);

    // Pattern 11, non-overlap: 1111 hits after bits 2 and 4
    load(8'b0000_0011, 4'd2, 1'b0, 1'b0, 1'b0);
    check("load_clr_cnt", 32'(match_count), 32'd0);
    send_pin("nonovl_det", 8'b0000_1111, 8'b0000_0101, 4);
    check("nonovl_cnt", 32'(match_count), 32'd2);

    // Pattern 11, overlap: hits after bits 2,3,4
    load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0);
    send_pin("ovl_det", 8'b0000_1111, 8'b0000_0111, 4);
    check("ovl_cnt", 32'(match_count), 32'd3);

    // Non-overlap with 3-cycle valid gaps: detect held through gaps
    load(8'b0000_0011, 4'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int g = 0; g < 3; g++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("gap_hit1", 32'(detector_out), 32'd1);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b0);
      check("gap_hold", 32'(detector_out), 32'd1);
    end
    step(1'b1, 1'b1);
    check("gap_miss", 32'(detector_out), 32'd0);
    for (int g = 0; g < 3; g++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("gap_hit2", 32'(detector_out), 32'd1);
    check("gap_cnt", 32'(match_count), 32'd2);

    // Load 11001010 len 8 with a valid '1' in the same cycle: bit dropped
    load(8'b1100_1010, 4'd8, 1'b1, 1'b1, 1'b1);
    check("load8_cnt", 32'(match_count), 32'd0);
    send_pin("load8_drop", 8'b0100_1010, 8'b0000_0000, 7);
    send_pin("load8_det", 8'b1100_1010, 8'b0000_0001, 8);
    check("load8_cnt1", 32'(match_count), 32'd1);

    // Illegal length 0: error, data ignored
    load(8'b0000_1011, 4'd0, 1'b1, 1'b0, 1'b0);
    check("err_len0", 32'(cfg_err), 32'd1);
    send_pin("err_det", 8'b0000_1011, 8'b0000_0000, 4);
    check("err_cnt", 32'(match_count), 32'd0);
    // Illegal length above MAX_LEN
    load(8'b0000_1011, 4'd9, 1'b1, 1'b0, 1'b0);
    check("err_len9", 32'(cfg_err), 32'd1);
    // Legal load recovers
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    check("err_clear", 32'(cfg_err), 32'd0);
    send_pin("recover_det", 8'b0000_1011, 8'b0000_0001, 4);

    // Length 1, non-overlap: six 1s, counter saturates at 3
    load(8'b0000_0001, 4'd1, 1'b0, 1'b0, 1'b0);
    send_pin("len1_det", 8'b0011_1111, 8'b0011_1111, 6);
    check("sat_cnt", 32'(match_count), 32'd3);
    step(1'b1, 1'b0);
    check("len1_zero", 32'(detector_out), 32'd0);
    step(1'b1, 1'b1);
    check("len1_again", 32'(detector_out), 32'd1);

    // Reset while in MATCH, with a cfg_load also asserted (reset wins)
    @(negedge clock);
    reset = 1'b1; cfg_load = 1'b1; cfg_len = 4'd0; in_valid = 1'b1; sequence_in = 1'b1;
    @(posedge clock); #2;
    check("rst_det", 32'(detector_out), 32'd0);
    check("rst_cnt", 32'(match_count), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    step(1'b0, 1'b0);
    send_pin("post_rst_det", 8'b0000_1011, 8'b0000_0001, 4);

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
